signal_conditioner: RTL and testbench

- Upstream stage of the edge detector: turns an asynchronous, bouncy external input into a clean, clock-synchronous level.
- `signal_out` connects directly to the edge detector's `signal_in`, so every `pos_edge`/`neg_edge` pulse corresponds to one real, debounced transition.
- Structure: a multi-flop synchronizer followed by a debounce FSM with a stability counter.
- Optional: a saturating counter of rejected glitches.

---
 rtl/signal_conditioner.sv | 156 +++++++++++++++
 tb/tb_signal_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/signal_conditioner.sv
// ----------------------------------------------------------------------------
// signal_conditioner
//
// Turns an asynchronous, possibly bouncing external input into a clean,
// clock-synchronous level for the downstream edge detector. A SYNC_STAGES-deep
// flop chain brings raw_in into the clk domain. A two-state debounce FSM
// (STABLE / CHECK) then only lets signal_out follow the synchronized value
// after DEBOUNCE_CYCLES consecutive samples that disagree with it.
//
// Optional feature macro: SIGNAL_COND_GLITCH_CNT_EN
//   defined   : glitch_count is a saturating count of rejected candidates
//   undefined : glitch_count is tied to zero and no counter flops exist
//
// Parameters
//   SYNC_STAGES     synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES stable samples needed before signal_out changes (>= 1)
//   GLITCH_W        width of glitch_count
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   raw_in       asynchronous external input
//   signal_out   debounced, registered level
//   busy         registered, high while a candidate transition is qualified
//   glitch_count rejected candidate transitions (saturating)
// ----------------------------------------------------------------------------
module signal_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                raw_in,
   output logic                signal_out,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_count
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // cnt + 1 == DEBOUNCE_CYCLES is the same test as cnt == DEBOUNCE_CYCLES - 1
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_chain_d, sync_chain_q;
   logic                   sync_q;
   state_t                 state_d, state_q;
   logic [CNT_W-1:0]       cnt_d, cnt_q;
   logic                   signal_out_d, signal_out_q;
   logic                   busy_d, busy_q;

   // Synchronizer shift: bit 0 takes raw_in, the top bit is the synchronized sample.
   always_comb begin
      sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], raw_in};
   end

   assign sync_q = sync_chain_q[SYNC_STAGES-1];

   // Debounce next-state logic; bounce-back is tested before counter completion.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      signal_out_d = signal_out_q;
      case (state_q)
         ST_STABLE: begin
            cnt_d = {CNT_W{1'b0}};
            if (sync_q != signal_out_q) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  // A single agreeing sample is already enough qualification
                  signal_out_d = ~signal_out_q;
                  state_d      = ST_STABLE;
               end else begin
                  cnt_d   = CNT_W'(1);
                  state_d = ST_CHECK;
               end
            end else begin
               state_d = ST_STABLE;
            end
         end
         ST_CHECK: begin
            if (sync_q == signal_out_q) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_STABLE;
            end else if (cnt_q == CNT_LAST) begin
               signal_out_d = ~signal_out_q;
               cnt_d        = {CNT_W{1'b0}};
               state_d      = ST_STABLE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = ST_CHECK;
            end
         end
         default: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_STABLE;
         end
      endcase
      // busy is a registered copy of "next state is CHECK"
      busy_d = (state_d == ST_CHECK);
   end

   // Synchronizer, FSM, counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_chain_q <= {SYNC_STAGES{1'b0}};
         state_q      <= ST_STABLE;
         cnt_q        <= {CNT_W{1'b0}};
         signal_out_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         sync_chain_q <= sync_chain_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         signal_out_q <= signal_out_d;
         busy_q       <= busy_d;
      end
   end

   assign signal_out = signal_out_q;
   assign busy       = busy_q;

`ifdef SIGNAL_COND_GLITCH_CNT_EN
   logic                glitch_inc_s;
   logic [GLITCH_W-1:0] glitch_d, glitch_q;

   // A candidate is rejected when CHECK sees the input fall back to the output level.
   assign glitch_inc_s = (state_q == ST_CHECK) && (sync_q == signal_out_q);

   // Saturating increment: holds at all-ones instead of wrapping.
   always_comb begin
      if (glitch_inc_s && (glitch_q != {GLITCH_W{1'b1}})) begin
         glitch_d = glitch_q + GLITCH_W'(1);
      end else begin
         glitch_d = glitch_q;
      end
   end

   // Glitch counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch_q <= {GLITCH_W{1'b0}};
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_count = glitch_q;
`else
   assign glitch_count = {GLITCH_W{1'b0}};
`endif

endmodule

// File: tb/tb_signal_conditioner.sv
// ----------------------------------------------------------------------------
// tb_signal_conditioner
//
// Directed bench for signal_conditioner with default parameters, plus a second
// instance with GLITCH_W=2 for counter saturation. Expected signal_out
// transitions (value and the clock edge after which they must be visible) are
// queued by the stimulus; a monitor pops and compares on every observed change.
// A behavioural edge detector fed from signal_out counts downstream pulses.
// ----------------------------------------------------------------------------
module tb_signal_conditioner;

`ifdef SIGNAL_COND_GLITCH_CNT_EN
   localparam bit GC_EN = 1'b1;
`else
   localparam bit GC_EN = 1'b0;
`endif

   logic       clk    = 1'b1;
   logic       rst    = 1'b0;
   logic       raw_in = 1'b0;
   logic       raw2   = 1'b0;
   logic       signal_out, busy;
   logic [7:0] glitch_count;
   logic       so2, busy2;
   logic [1:0] gc2;

   signal_conditioner dut (
      .clk          (clk),
      .rst          (rst),
      .raw_in       (raw_in),
      .signal_out   (signal_out),
      .busy         (busy),
      .glitch_count (glitch_count)
   );

   signal_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(2)) dut_sat (
      .clk          (clk),
      .rst          (rst),
      .raw_in       (raw2),
      .signal_out   (so2),
      .busy         (busy2),
      .glitch_count (gc2)
   );

   // 10 ns clock; rising edges at 10, 20, 30 ... ns
   always #5 clk = ~clk;

   // Rising-edge index; read at falling edges
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream edge detector model
   logic sig_d   = 1'b0;
   int   pos_cnt = 0;
   int   neg_cnt = 0;
   always @(posedge clk) begin
      sig_d <= signal_out;
      if (signal_out && !sig_d) pos_cnt <= pos_cnt + 1;
      if (!signal_out && sig_d) neg_cnt <= neg_cnt + 1;
   end

   typedef struct {
      logic val;
      int   cyc;
   } exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic v, input int c);
      exp_t e;
      e.val = v;
      e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic negs(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every observed signal_out change must match the head of the queue
   initial begin
      logic mon_prev;
      exp_t e;
      mon_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (signal_out !== mon_prev) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL signal_out_edge: unexpected change to %0b after edge %0d", signal_out, cyc);
            end else begin
               e = exp_q.pop_front();
               check("signal_out_value", int'(signal_out), int'(e.val));
               check("signal_out_edge_index", cyc, e.cyc);
            end
            mon_prev = signal_out;
         end
      end
   end

   initial begin
      int bc;
      int base;
      int a;

      // Reset asserted from 1 ns, released at the 15 ns falling edge
      #1 rst = 1'b1;
      #11;
      check("reset_signal_out", int'(signal_out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_glitch_count", int'(glitch_count), 0);

      // 1. Clean rise: raw_in high before the first sampling edge
      @(negedge clk);
      rst    = 1'b0;
      raw_in = 1'b1;
      push_exp(1'b1, cyc + 1 + 5);
      bc = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy) bc++;
      end
      check("rise_busy_cycles", bc, 3);
      check("rise_signal_out", int'(signal_out), 1);
      check("rise_glitch_count", int'(glitch_count), 0);

      // 4. Clean fall
      base   = neg_cnt;
      raw_in = 1'b0;
      push_exp(1'b0, cyc + 1 + 5);
      negs(10);
      check("fall_neg_edges", neg_cnt - base, 1);
      check("fall_signal_out", int'(signal_out), 0);

      // 2. Bounce rejection: three 2-cycle pulses
      repeat (3) begin
         raw_in = 1'b1;
         negs(2);
         raw_in = 1'b0;
         negs(2);
      end
      negs(4);
      check("bounce_glitch_count", int'(glitch_count), GC_EN ? 3 : 0);
      check("bounce_signal_out", int'(signal_out), 0);

      // 3. Bounce then settle: 1,0 single-cycle, then 1 held
      base   = pos_cnt;
      a      = cyc + 1;
      raw_in = 1'b1;
      negs(1);
      raw_in = 1'b0;
      negs(1);
      raw_in = 1'b1;
      push_exp(1'b1, a + 7);
      negs(12);
      check("settle_pos_edges", pos_cnt - base, 1);
      check("settle_glitch_count", int'(glitch_count), GC_EN ? 4 : 0);
      check("settle_signal_out", int'(signal_out), 1);

      // 5. Reset while a falling candidate is in CHECK
      raw_in = 1'b0;
      negs(3);
      check("pre_reset_busy", int'(busy), 1);
      #1;
      rst = 1'b1;
      push_exp(1'b0, cyc + 1);
      #1;
      check("async_reset_signal_out", int'(signal_out), 0);
      check("async_reset_busy", int'(busy), 0);
      check("async_reset_glitch_count", int'(glitch_count), 0);
      raw_in = 1'b1;
      #5;
      rst = 1'b0;
      push_exp(1'b1, cyc + 1 + 5);
      negs(10);
      check("post_reset_signal_out", int'(signal_out), 1);

      // 6. Saturation on the GLITCH_W=2 instance: five 1-cycle pulses
      for (int i = 0; i < 5; i++) begin
         raw2 = 1'b1;
         negs(1);
         raw2 = 1'b0;
         negs(3);
         if (i == 2) check("sat_after_3", int'(gc2), GC_EN ? 3 : 0);
      end
      check("sat_after_5", int'(gc2), GC_EN ? 3 : 0);
      negs(5);
      check("sat_hold", int'(gc2), GC_EN ? 3 : 0);
      check("sat_signal_out", int'(so2), 0);

      // Every queued transition must have been observed
      check("pending_expected_edges", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
